instr_fetch: RTL and testbench

- Fetch stage that sits directly upstream of the IF pipeline register.
- Holds the 8-bit PC and issues requests to a variable-latency instruction memory with a req/ack handshake.
- Buffers returned 16-bit instructions in a small queue and presents {PC2, inst} to the IF register each cycle.
- Handles downstream stall and branch/jump redirect with a flush.

---
 rtl/instr_fetch.sv | 110 +++++++++++
 tb/tb_instr_fetch.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, runs a one-outstanding req/ack fetch to
// instruction memory and buffers {PC+2, inst} for the IF pipeline register.
module instr_fetch #(
   parameter logic [7:0]  RESET_PC = 8'h00,
   parameter int          QDEPTH   = 2,
   parameter logic [15:0] NOP_INST = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [7:0]  imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [7:0]  redirect_pc,
   output logic [7:0]  PC2,
   output logic [15:0] inst,
   output logic        inst_valid
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = $clog2(QDEPTH + 1);
   localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      KILL = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    pc_q;
   logic [7:0]    kill_addr_q;
   logic [23:0]   q_mem [QDEPTH];
   logic [PW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_after_push;
   logic          push;
   logic          pop;

   // Redirect wins over everything: the returning word is dropped and nothing pops.
   assign push             = (state_q == REQ) && imem_ack && !redirect;
   assign pop              = inst_valid && !stall && !redirect;
   assign count_after_push = count_q + CW'(push) - CW'(pop);

   assign inst_valid = (count_q != '0);
   assign inst       = inst_valid ? q_mem[rd_ptr_q][15:0]  : NOP_INST;
   assign PC2        = inst_valid ? q_mem[rd_ptr_q][23:16] : 8'h00;
   assign imem_req   = (state_q != IDLE);
   // While killing, the abandoned address stays on the bus until its ack arrives.
   assign imem_addr  = (state_q == KILL) ? kill_addr_q : pc_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (redirect || (count_q < QFULL)) state_d = REQ;
         end
         REQ: begin
            if (redirect) begin
               state_d = imem_ack ? REQ : KILL;
            end else if (imem_ack) begin
               state_d = (count_after_push < QFULL) ? REQ : IDLE;
            end
         end
         KILL: begin
            if (imem_ack) state_d = REQ;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q        <= RESET_PC;
         kill_addr_q <= RESET_PC;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
      end else if (redirect) begin
         pc_q     <= redirect_pc & 8'hFE;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         if ((state_q == REQ) && !imem_ack) kill_addr_q <= pc_q;
      end else begin
         if (push) begin
            pc_q     <= pc_q + 8'd2;
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_after_push;
      end
   end

   // Payload storage needs no reset; validity comes from count_q.
   always_ff @(posedge clk) begin
      if (push) q_mem[wr_ptr_q] <= {pc_q + 8'd2, imem_rdata};
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: a variable-latency memory model drives the
// handshake and a transaction-level queue model predicts the IF-side outputs.
module tb_instr_fetch;

   localparam logic [7:0]  RESET_PC = 8'hFC;
   localparam int          QDEPTH   = 2;
   localparam logic [15:0] NOP_INST = 16'h0000;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic        stall;
   logic        redirect;
   logic [7:0]  redirect_pc;
   logic [7:0]  PC2;
   logic [15:0] inst;
   logic        inst_valid;

   always #5 clk = ~clk;

   instr_fetch #(
      .RESET_PC (RESET_PC),
      .QDEPTH   (QDEPTH),
      .NOP_INST (NOP_INST)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .PC2         (PC2),
      .inst        (inst),
      .inst_valid  (inst_valid)
   );

   // ---------------- scoreboard / model state ----------------
   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] mem_tbl [256];
   logic [23:0] exp_q[$];          // {pc2, inst} in delivery order
   logic [7:0]  m_pc;              // next address whose data will be accepted
   logic [7:0]  m_kill_addr;
   logic        m_kill;            // an abandoned request is still on the bus
   logic        m_in_reset;
   logic        prev_wait;
   logic        prev_gap;
   bit          busy;
   int          lat_left;
   int          lat_lo, lat_hi, p_stall, p_redir;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- driver: one clock cycle ----------------
   task automatic do_cycle(input logic rst_v, input bit force_stall);
      logic [23:0] head;
      @(negedge clk);
      rst        = rst_v;
      imem_ack   = 1'b0;
      imem_rdata = 16'($urandom);
      if (!rst_v) begin
         busy = 1'b0;
      end else if (imem_req) begin
         if (!busy) begin
            busy     = 1'b1;
            lat_left = int'($urandom_range(lat_hi, lat_lo));
         end
         if (lat_left == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_tbl[imem_addr];
            busy       = 1'b0;
         end else begin
            lat_left--;
         end
      end else begin
         busy = 1'b0;
      end
      stall       = force_stall || (int'($urandom_range(99, 0)) < p_stall);
      redirect    = (int'($urandom_range(99, 0)) < p_redir);
      redirect_pc = 8'($urandom);
      #1;

      // outputs against the model
      if (m_in_reset) begin
         check_eq("rst_req", imem_req, 1'b0);
         check_eq("rst_addr", imem_addr, RESET_PC);
      end
      check_eq("inst_valid", inst_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
         head = exp_q[0];
         check_eq("inst", inst, head[15:0]);
         check_eq("pc2", PC2, head[23:16]);
      end else begin
         check_eq("inst_nop", inst, NOP_INST);
         check_eq("pc2_zero", PC2, 8'h00);
      end
      if (!m_in_reset) begin
         if (imem_req) check_eq("imem_addr", imem_addr, m_kill ? m_kill_addr : m_pc);
         if (prev_wait) check_eq("req_hold", imem_req, 1'b1);
         if (!m_kill && exp_q.size() >= QDEPTH) check_eq("req_when_full", imem_req, 1'b0);
         if (prev_gap && exp_q.size() < QDEPTH) check_eq("req_restart", imem_req, 1'b1);
         prev_gap = !imem_req && (exp_q.size() < QDEPTH);
      end else begin
         prev_gap = 1'b0;
      end
      prev_wait = rst_v && imem_req && !imem_ack;

      // model update for the coming edge
      if (!rst_v) begin
         exp_q.delete();
         m_pc       = RESET_PC;
         m_kill     = 1'b0;
         m_in_reset = 1'b1;
      end else begin
         m_in_reset = 1'b0;
         if (redirect) begin
            exp_q.delete();
            if (imem_req && !imem_ack && !m_kill) begin
               m_kill      = 1'b1;
               m_kill_addr = m_pc;
            end else if (imem_req && imem_ack) begin
               m_kill = 1'b0;
            end
            m_pc = redirect_pc & 8'hFE;
         end else begin
            if (exp_q.size() != 0 && !stall) void'(exp_q.pop_front());
            if (imem_req && imem_ack) begin
               if (m_kill) begin
                  m_kill = 1'b0;
               end else begin
                  exp_q.push_back({m_pc + 8'd2, mem_tbl[m_pc]});
                  m_pc = m_pc + 8'd2;
               end
            end
         end
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit hit;
      rst         = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 8'h00;
      imem_ack    = 1'b0;
      imem_rdata  = 16'h0000;
      exp_q.delete();
      m_pc        = RESET_PC;
      m_kill_addr = RESET_PC;
      m_kill      = 1'b0;
      m_in_reset  = 1'b1;
      prev_wait   = 1'b0;
      prev_gap    = 1'b0;
      busy        = 1'b0;
      lat_left    = 0;
      for (int i = 0; i < 256; i++) mem_tbl[i] = 16'hA000 + 16'(i);

      // startup with zero-wait memory; addresses wrap past 8'hFF
      lat_lo = 0; lat_hi = 0; p_stall = 0; p_redir = 0;
      for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b0);
      for (int i = 0; i < 16; i++) do_cycle(1'b1, 1'b0);

      // fixed 3-cycle latency with a 10-cycle stall, then drain
      lat_lo = 3; lat_hi = 3;
      for (int i = 0; i < 10; i++) do_cycle(1'b1, 1'b1);
      for (int i = 0; i < 20; i++) do_cycle(1'b1, 1'b0);

      // random data, latency, stall and redirect
      for (int i = 0; i < 256; i++) mem_tbl[i] = 16'($urandom);
      lat_lo = 0; lat_hi = 3; p_stall = 30; p_redir = 8;
      for (int i = 0; i < 800; i++) do_cycle(1'b1, 1'b0);

      // zero-wait memory with frequent redirects lands them on ack cycles
      lat_lo = 0; lat_hi = 0; p_stall = 20; p_redir = 25;
      for (int i = 0; i < 150; i++) do_cycle(1'b1, 1'b0);

      // reset taken while a killed request is still outstanding
      lat_lo = 2; lat_hi = 4; p_stall = 20; p_redir = 30;
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         do_cycle(1'b1, 1'b0);
         hit = m_kill;
      end
      check_eq("kill_reached", hit, 1'b1);
      for (int i = 0; i < 2; i++) do_cycle(1'b0, 1'b0);
      p_redir = 5;
      for (int i = 0; i < 60; i++) do_cycle(1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
